// File: rtl/ser_pkg.sv
// Shared types and defaults for the serial transmitter.
// S_PAR is only reachable when SER_PARITY_EN is defined.
package ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2
    } state_t;

    localparam int SER_W_DEF = 8;

endpackage

// File: rtl/ser_pend_buf.sv
// Single-entry holding register for the word queued behind the one being shifted.
module ser_pend_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load,
    input  logic         take,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         pend_vld
);

    logic [W-1:0] data_q, data_d;
    logic         vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (take) begin
            vld_d = 1'b0;
        end else if (load) begin
            data_d = din;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign dout     = data_q;
    assign pend_vld = vld_q;

endmodule

// File: rtl/ser_tx_stream.sv
// Parallel-to-serial transmitter with one pending word; feeds the pattern detector.
// Optional even-parity bit after each word: define SER_PARITY_EN.
//
// state   | meaning
// S_IDLE  | no word active, SER_OUT at IDLE_LVL
// S_SHIFT | data bit cnt of the active word on SER_OUT
// S_PAR   | parity bit of the active word on SER_OUT
module ser_tx_stream
    import ser_pkg::*;
#(
    parameter int   W         = SER_W_DEF,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_LVL  = 1'b1
) (
    input  logic         clk,
    input  logic         res,
    input  logic [W-1:0] DIN,
    input  logic         DIN_VLD,
    output logic         DIN_RDY,
    output logic         SER_OUT,
    output logic         SER_ACT,
    output logic         WORD_DONE
);

    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ser_q, ser_d;
    logic           pend_vld, pend_load, pend_take;
    logic [W-1:0]   pend_data;
    logic [W-1:0]   next_word;
    logic           accept, word_end, do_load;
`ifdef SER_PARITY_EN
    logic           par_q, par_d;
`endif

    function automatic logic first_bit(input logic [W-1:0] w);
        return MSB_FIRST ? w[W-1] : w[0];
    endfunction

    function automatic logic [W-1:0] shift_word(input logic [W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign DIN_RDY = !pend_vld && !res;
    assign accept  = DIN_VLD && DIN_RDY;

`ifdef SER_PARITY_EN
    assign word_end = (state_q == S_PAR);
`else
    assign word_end = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
`endif

    // Only a word arriving while the shifter is free bypasses the buffer.
    assign pend_load = accept && !((state_q == S_IDLE) || word_end);

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        ser_d     = ser_q;
        pend_take = 1'b0;
        next_word = DIN;
        do_load   = 1'b0;
`ifdef SER_PARITY_EN
        par_d     = par_q;
`endif

        if (state_q == S_IDLE) begin
            do_load = accept;
        end else if (word_end) begin
            if (pend_vld) begin
                do_load   = 1'b1;
                pend_take = 1'b1;
                next_word = pend_data;
            end else begin
                do_load = accept;
            end
        end

        if (do_load) begin
            state_d = S_SHIFT;
            ser_d   = first_bit(next_word);
            sh_d    = shift_word(next_word);
            cnt_d   = '0;
`ifdef SER_PARITY_EN
            par_d   = ^next_word;
`endif
        end else if (state_q == S_SHIFT && !word_end) begin
`ifdef SER_PARITY_EN
            if (cnt_q == CNT_LAST) begin
                state_d = S_PAR;
                ser_d   = par_q;
                cnt_d   = CW'(W);
            end else begin
                ser_d = first_bit(sh_q);
                sh_d  = shift_word(sh_q);
                cnt_d = cnt_q + 1'b1;
            end
`else
            ser_d = first_bit(sh_q);
            sh_d  = shift_word(sh_q);
            cnt_d = cnt_q + 1'b1;
`endif
        end else begin
            state_d = S_IDLE;
            ser_d   = IDLE_LVL;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            ser_q   <= IDLE_LVL;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    ser_pend_buf #(.W(W)) u_pend (
        .clk      (clk),
        .res      (res),
        .load     (pend_load),
        .take     (pend_take),
        .din      (DIN),
        .dout     (pend_data),
        .pend_vld (pend_vld)
    );

    assign SER_OUT   = ser_q;
    assign SER_ACT   = (state_q != S_IDLE);
    assign WORD_DONE = word_end;

endmodule

// File: tb/tb_ser_tx_stream.sv
// Bench for ser_tx_stream: MSB-first and LSB-first instances share stimulus and
// are checked against a bit-queue model of the serial stream.
module tb_ser_tx_stream;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int P   = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int P   = W;
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         res = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_vld = 1'b0;
    logic         rdy_m, ser_m, act_m, done_m;
    logic         rdy_l, ser_l, act_l, done_l;

    ser_tx_stream #(.W(W), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_msb (
        .clk(clk), .res(res), .DIN(din), .DIN_VLD(din_vld), .DIN_RDY(rdy_m),
        .SER_OUT(ser_m), .SER_ACT(act_m), .WORD_DONE(done_m)
    );

    ser_tx_stream #(.W(W), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_lsb (
        .clk(clk), .res(res), .DIN(din), .DIN_VLD(din_vld), .DIN_RDY(rdy_l),
        .SER_OUT(ser_l), .SER_ACT(act_l), .WORD_DONE(done_l)
    );

    // Model: every accepted word appends its P bits to a queue; one bit leaves per cycle.
    typedef struct packed {
        logic bm;
        logic bl;
        logic dn;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    logic cur_act = 1'b0;
    logic m_rdy;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic push_word(input logic [W-1:0] w);
        ent_t e;
        for (int i = 0; i < W; i++) begin
            e.bm = w[W-1-i];
            e.bl = w[i];
            e.dn = (!PAR && i == W - 1);
            q.push_back(e);
        end
        if (PAR) begin
            e.bm = ^w;
            e.bl = ^w;
            e.dn = 1'b1;
            q.push_back(e);
        end
    endtask

    // Pending slot is occupied exactly when a full word sits behind the shown bit.
    task automatic step();
        m_rdy = !res && (q.size() < P);
        @(posedge clk);
        if (res) begin
            q.delete();
            cur_act = 1'b0;
        end else begin
            if (din_vld && m_rdy) push_word(din);
            if (q.size() > 0) begin
                cur     = q.pop_front();
                cur_act = 1'b1;
            end else begin
                cur_act = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [7:0] got_v();
        return {ser_m, ser_l, act_m, act_l, done_m, done_l, rdy_m, rdy_l};
    endfunction

    function automatic logic [7:0] exp_v();
        logic r;
        r = !res && (q.size() < P);
        return {cur_act ? cur.bm : 1'b1, cur_act ? cur.bl : 1'b1,
                cur_act, cur_act, cur_act && cur.dn, cur_act && cur.dn, r, r};
    endfunction

    task automatic test_reset();
        res = 1'b1;
        din_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({ser_m, act_m, rdy_m, rdy_l} !== 4'b1000) begin
                n_err++;
                $display("FAIL reset_hold got=%b exp=1000", {ser_m, act_m, rdy_m, rdy_l});
            end
        end
        res = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_err++;
                $display("FAIL idle_model cyc=%0d got=%b exp=%b", i, got_v(), exp_v());
            end
            n_cmp++;
            if ({ser_m, act_m, rdy_m} !== 3'b101) begin
                n_err++;
                $display("FAIL idle_after_reset got=%b exp=101", {ser_m, act_m, rdy_m});
            end
        end
    endtask

    task automatic test_single(input logic [W-1:0] w);
        din = w;
        din_vld = 1'b1;
        step();
        din_vld = 1'b0;
        din = W'($urandom);
        for (int i = 0; i < P + 2; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_err++;
                $display("FAIL single_model w=%h cyc=%0d got=%b exp=%b", w, i, got_v(), exp_v());
            end
            n_cmp++;
            if ({ser_m, ser_l, act_m, done_m} !==
                {(i < W) ? w[W-1-i] : ((i < P) ? ^w : 1'b1),
                 (i < W) ? w[i]     : ((i < P) ? ^w : 1'b1),
                 i < P, i == P - 1}) begin
                n_err++;
                $display("FAIL single_bits w=%h cyc=%0d got=%b", w, i, {ser_m, ser_l, act_m, done_m});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] stream;
        logic [17:0] exp_s;
        int          n_act;
        int          n_done;
        stream = '0;
        n_act  = 0;
        n_done = 0;
        if (PAR) exp_s = {8'hA5, 1'b0, 8'h3C, 1'b0};
        else     exp_s = {2'b00, 8'hA5, 8'h3C};
        din = 8'hA5;
        din_vld = 1'b1;
        for (int i = 0; i < 2 * P + 3; i++) begin
            step();
            if (i == 0) din = 8'h3C;
            if (i == 1) din_vld = 1'b0;
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_err++;
                $display("FAIL b2b_model cyc=%0d got=%b exp=%b", i, got_v(), exp_v());
            end
            if (i < 2 * P) stream = {stream[16:0], ser_m};
            n_act  += act_m;
            n_done += done_m;
            if (i >= 1 && i < P) begin
                n_cmp++;
                if (rdy_m !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_rdy cyc=%0d got=%b exp=0", i, rdy_m);
                end
            end
        end
        n_cmp++;
        if (stream !== exp_s || n_act != 2 * P || n_done != 2) begin
            n_err++;
            $display("FAIL b2b_stream got=%b act=%0d done=%0d exp=%b act=%0d done=2",
                     stream, n_act, n_done, exp_s, 2 * P);
        end
    endtask

    task automatic test_mid_reset();
        din = 8'hFF;
        din_vld = 1'b1;
        step();
        din = 8'h00;
        step();
        din_vld = 1'b0;
        step();
        step();
        res = 1'b1;
        step();
        n_cmp++;
        if ({ser_m, act_m, done_m, rdy_m} !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_idle got=%b exp=1000", {ser_m, act_m, done_m, rdy_m});
        end
        res = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            step();
            n_cmp++;
            if (got_v() !== exp_v() || act_m !== 1'b0 || ser_m !== 1'b1) begin
                n_err++;
                $display("FAIL midrst_after cyc=%0d got=%b exp=%b", i, got_v(), exp_v());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            din_vld = ($urandom_range(0, 3) != 0);
            din     = W'($urandom);
            res     = ($urandom_range(0, 149) == 0);
            step();
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, got_v(), exp_v());
            end
        end
        res = 1'b0;
        din_vld = 1'b0;
        for (int i = 0; i < 2 * P + 2; i++) begin
            step();
            n_cmp++;
            if (got_v() !== exp_v()) begin
                n_err++;
                $display("FAIL random_drain cyc=%0d got=%b exp=%b", i, got_v(), exp_v());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single(8'h10);
        test_single(8'h01);
        test_single(8'h07);
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ser_tx_stream.md
Name: ser_tx_stream

Overview:
- Parallel-to-serial transmitter that drives the serial bit line read by the Moore pattern detector; its SER_OUT connects directly to the detector's INP.
- Accepts W-bit words over a valid/ready handshake and buffers at most one pending word behind the word being shifted.
- Shifts one bit per clock, with no gap between back-to-back words.
- Holds SER_OUT at a fixed idle level when it has no data.

Parameters:
- W, 8: data word width; must be 2 or more.
- MSB_FIRST, 1: 1 = bit W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LVL, 1'b1: level driven on SER_OUT when no word is active.

Ports:
- clk, input, 1: rising-edge clock.
- res, input, 1: synchronous reset, active-high.
- DIN, input, W: word to transmit.
- DIN_VLD, input, 1: DIN is valid.
- DIN_RDY, output, 1: block can accept a word. Transfer occurs on a clock edge where DIN_VLD=1 and DIN_RDY=1.
- SER_OUT, output, 1: registered serial bit; connects to detector INP.
- SER_ACT, output, 1: SER_OUT carries a data or parity bit (not idle level).
- WORD_DONE, output, 1: one-cycle pulse while the final bit of a word is on SER_OUT.

Behaviour:
- Interface: one clock, clk. Reset res is synchronous and active-high.
- Reset: while res=1, at each clk edge:
  - state -> S_IDLE
  - pending buffer emptied
  - SER_OUT=IDLE_LVL, SER_ACT=0, WORD_DONE=0
- DIN_RDY = !pend_vld and is forced to 0 while res=1.
- Reset mid-word discards both the active and the pending word. There is no partial completion. SER_OUT returns to IDLE_LVL on the edge where res is sampled high.
- State machine, state_t:
  - S_IDLE, S_SHIFT, plus S_PAR when the optional feature is compiled in.
- S_IDLE:
  - A word accepted at edge N loads the shift register directly, bypassing the pending buffer.
  - From edge N onward, SER_OUT = first bit and SER_ACT=1. Latency is one cycle from acceptance to first bit.
  - Bit counter cnt is cleared to 0.
- S_SHIFT: at each edge, advance one bit and increment cnt.
- Last bit (cnt==W-1) is shown with WORD_DONE=1. At the following edge:
  - If pend_vld=1: load the pending word, set pend_vld=0, cnt=0, stay in S_SHIFT. No idle gap.
  - Else if DIN_VLD=1 (DIN_RDY is 1 because the buffer is empty): load DIN directly, cnt=0, stay in S_SHIFT. No gap.
  - Else: go to S_IDLE, SER_OUT=IDLE_LVL, SER_ACT=0.
- Accepting a word in S_SHIFT when cnt is not W-1: the word goes to the pending buffer, pend_vld=1, and DIN_RDY drops on the next cycle.
- Maximum storage is 2 words (active + pending).
- Sustained throughput is one word per W cycles (W+1 with parity).
- DIN is sampled only on a transfer edge. Later changes to DIN do not affect the word already captured.
- cnt width is $clog2(W+1). cnt never exceeds W.
- DIN_VLD while DIN_RDY=0 is ignored. The source must hold the word; it is not an error.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the W data bits, one extra bit is sent in state S_PAR: even parity, equal to the XOR of all data bits.
  - WORD_DONE moves to the parity bit.
  - Back-to-back load happens after the parity bit.
  - Word period is W+1 cycles.
- Undefined: no S_PAR state, no parity logic; word period is W cycles.

Decomposition:
- Package ser_pkg holds:
  - state_t enum: S_IDLE, S_SHIFT, S_PAR.
  - Constant SER_W_DEF = 8.
- One natural sub-module, ser_pend_buf: the single-entry holding register with pend_vld, load, and take. The FSM and shifter stay in ser_tx_stream.

Test Plan:
- Reset then idle: hold res=1 for 3 cycles, then DIN_VLD=0 for 10 cycles -> SER_OUT=1, SER_ACT=0, DIN_RDY=0 during reset and 1 after.
- Single word: W=8, MSB_FIRST=1, DIN=8'h10 accepted at edge N -> SER_OUT over cycles N..N+7 = 0,0,0,1,0,0,0,0. WORD_DONE only on cycle N+7. Idle from N+8. A downstream pattern detector fires on the 5th bit.
- Back-to-back: 8'hA5 then 8'h3C, DIN_VLD held high -> 16 contiguous bits 10100101 00111100, SER_ACT=1 throughout, WORD_DONE at cycles 8 and 16. DIN_RDY=0 from the cycle after the second accept until the second word loads.
- LSB first: MSB_FIRST=0, DIN=8'h01 -> 1,0,0,0,0,0,0,0.
- Mid-word reset: res=1 on the 4th bit of 8'hFF while 8'h00 is pending -> SER_OUT=1 and SER_ACT=0 from the next edge. No bits of 8'h00 are ever sent.
- Parity (SER_PARITY_EN defined): DIN=8'h07 -> 9 bits 00000111 then parity 1. WORD_DONE on the 9th bit.
